// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer blocks.
//   state_t : controller state encoding
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Interval tick generator: an up-counter that pulses tick on the clock in
// which it equals interval, then wraps to zero. Shared by PWM sequencers.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the interval from zero (wins over en)
//   en        : count this clock
//   interval  : clocks between ticks, minus 1
//   tick      : combinational, high when an enabled count hits interval
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] interval,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;

    assign tick = en && (count == interval);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == interval) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Duty ramp controller: accepts ramp commands and slews a registered duty
// toward the target by a fixed step once per interval, clamping at target.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : 0 pauses the ramp and blocks new commands
//   cmd_*         : valid/ready command (target, step, interval)
//   abort         : abandon the ramp, duty frozen
//   duty          : duty to the PWM generator
//   busy          : ramp in progress
//   done, aborted : one-cycle completion pulses
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for a command, cmd_ready follows enable
// RAMP    | stepping duty on each interval tick
// DONE    | target reached, done pulse, back to IDLE
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int STEP_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CNT_WIDTH-1:0]  cmd_target,
    input  logic [STEP_WIDTH-1:0] cmd_step,
    input  logic [DIV_WIDTH-1:0]  cmd_interval,
    input  logic                  abort,
    output logic [CNT_WIDTH-1:0]  duty,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    // One guard bit above the wider operand so sums never wrap and a
    // negative difference shows up in the MSB.
    localparam int AW = ((CNT_WIDTH > STEP_WIDTH) ? CNT_WIDTH : STEP_WIDTH) + 1;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  duty_nxt, duty_stepped;
    logic [CNT_WIDTH-1:0]  target_r;
    logic [STEP_WIDTH-1:0] step_r;
    logic [DIV_WIDTH-1:0]  interval_r;
    logic                  accept, tick, abort_evt;
    logic [AW-1:0]         duty_x, target_x, step_x, sum_x, diff_x;

    assign cmd_ready = !rst && enable && (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    pwm_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (enable && (state == ST_RAMP)),
        .interval (interval_r),
        .tick     (tick)
    );

    assign duty_x   = AW'(duty);
    assign target_x = AW'(target_r);
    assign step_x   = AW'(step_r);
    assign sum_x    = duty_x + step_x;
    assign diff_x   = duty_x - step_x;

    always_comb begin
        duty_stepped = target_r;
        if (target_x > duty_x) begin
            if (sum_x < target_x) duty_stepped = sum_x[CNT_WIDTH-1:0];
        end else begin
            if (!diff_x[AW-1] && (diff_x > target_x)) duty_stepped = diff_x[CNT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        abort_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = (cmd_target == duty) ? ST_DONE : ST_RAMP;
            end
            ST_RAMP: begin
                if (enable) begin
                    // abort takes priority: a coincident tick is dropped
                    if (abort) begin
                        state_nxt = ST_IDLE;
                        abort_evt = 1'b1;
                    end else if (tick) begin
                        duty_nxt = duty_stepped;
                        if (duty_stepped == target_r) state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            target_r   <= '0;
            step_r     <= '0;
            interval_r <= '0;
        end else begin
            state   <= state_nxt;
            duty    <= duty_nxt;
            busy    <= (state_nxt == ST_RAMP);
            done    <= (state_nxt == ST_DONE);
            aborted <= abort_evt;
            if (accept) begin
                target_r   <= cmd_target;
                step_r     <= (cmd_step == '0) ? STEP_WIDTH'(1) : cmd_step;
                interval_r <= cmd_interval;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
module tb_pwm_ramp_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_target = '0;
    logic [7:0]  cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic        abort = 1'b0;
    logic [7:0]  duty;
    logic        busy, done, aborted;

    int total = 0;
    int bad = 0;
    int mdl_duty = 0;

    typedef struct {
        int duty;
        int k;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    pwm_ramp_controller dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_interval (cmd_interval),
        .abort        (abort),
        .duty         (duty),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    function automatic int model_step(input int d, input int t, input int s);
        int s0;
        s0 = (s == 0) ? 1 : s;
        if (t > d) return (d + s0 >= t) ? t : d + s0;
        else       return (d - s0 <= t) ? t : d - s0;
    endfunction

    // Offer a command at the current negedge; k counts edges after the
    // accepting edge. A pause of pl clocks starting at negedge pk shifts
    // every later expected change by pl.
    task automatic run_ramp(input int tgt, input int st, input int iv,
                            input int pk, input int pl, input string nm);
        int d, kk, last_k, prev;
        bit fin;
        exp_t e;
        d = mdl_duty;
        kk = 0;
        last_k = 0;
        while (d != tgt) begin
            kk += iv + 1;
            d = model_step(d, tgt, st);
            e.duty = d;
            e.k = (pk >= 0 && kk > pk) ? kk + pl : kk;
            sbq.push_back(e);
            last_k = e.k;
        end
        prev = mdl_duty;
        mdl_duty = tgt;

        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_cmd got=%0b want=1", nm, cmd_ready);
        end
        cmd_target   = tgt[7:0];
        cmd_step     = st[7:0];
        cmd_interval = iv[15:0];
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;

        fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            if (int'(duty) != prev) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected_change k=%0d got=%0d", nm, k, duty);
                end else begin
                    e = sbq.pop_front();
                    if (int'(duty) != e.duty || k != e.k) begin
                        bad++;
                        $display("FAIL %s duty got=%0d@%0d want=%0d@%0d", nm, duty, k, e.duty, e.k);
                    end
                end
                prev = int'(duty);
            end
            if (pk >= 0 && k == pk + 1) begin
                total++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s paused ready=%0b busy=%0b want ready=0 busy=1", nm, cmd_ready, busy);
                end
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                total++;
                if (k != last_k || sbq.size() != 0 || int'(duty) != tgt) begin
                    bad++;
                    $display("FAIL %s done_at got=%0d duty=%0d left=%0d want=%0d duty=%0d",
                             nm, k, duty, sbq.size(), last_k, tgt);
                end
            end
            if (pk >= 0 && k == pk)      enable = 1'b0;
            if (pk >= 0 && k == pk + pl) enable = 1'b1;
        end
        enable = 1'b1;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for done", nm);
        end
        sbq.delete();
        @(negedge clk);
        total++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done done=%0b ready=%0b busy=%0b want 0/1/0", nm, done, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%0b want=0", cmd_ready);
        end
        @(negedge clk);
        total++;
        if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs duty=%0d busy=%0b done=%0b aborted=%0b want all 0",
                     duty, busy, done, aborted);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%0b want=1", cmd_ready);
        end
        mdl_duty = 0;
    endtask

    task automatic test_up();
        run_ramp(10, 4, 0, -1, 0, "up");
    endtask

    task automatic test_down();
        run_ramp(200, 255, 0, -1, 0, "down_prep");
        run_ramp(50, 60, 3, -1, 0, "down");
    endtask

    task automatic test_extremes();
        run_ramp(250, 200, 0, -1, 0, "ext_250");
        run_ramp(255, 200, 0, -1, 0, "ext_255");
        run_ramp(0, 255, 0, -1, 0, "ext_zero");
        run_ramp(3, 0, 0, -1, 0, "ext_step0");
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (aborted !== 1'b0 || cmd_ready !== 1'b1 || int'(duty) != mdl_duty) begin
            bad++;
            $display("FAIL abort_idle aborted=%0b ready=%0b duty=%0d want 0/1/%0d",
                     aborted, cmd_ready, duty, mdl_duty);
        end
    endtask

    task automatic test_abort();
        int first;
        bit seen_done;
        first = model_step(mdl_duty, 100, 10);
        cmd_target = 8'd100;
        cmd_step = 8'd10;
        cmd_interval = 16'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
            if (k == 5) abort = 1'b1;
            if (k == 6) begin
                abort = 1'b0;
                total++;
                if (aborted !== 1'b1 || busy !== 1'b0 || int'(duty) != first || cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_pulse aborted=%0b busy=%0b duty=%0d ready=%0b want 1/0/%0d/1",
                             aborted, busy, duty, cmd_ready, first);
                end
            end
            if (k == 7) begin
                total++;
                if (aborted !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_one_cycle aborted=%0b want=0", aborted);
                end
            end
        end
        total++;
        if (seen_done || int'(duty) != first) begin
            bad++;
            $display("FAIL abort_no_done seen_done=%0b duty=%0d want 0/%0d", seen_done, duty, first);
        end
        mdl_duty = first;
    endtask

    task automatic test_reset_mid();
        cmd_target = 8'd200;
        cmd_step = 8'd1;
        cmd_interval = 16'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (int'(duty) != mdl_duty + 3) begin
            bad++;
            $display("FAIL rst_mid_pre duty=%0d want=%0d", duty, mdl_duty + 3);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (duty !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid duty=%0d busy=%0b ready=%0b want 0/0/0", duty, busy, cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || duty !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_release ready=%0b duty=%0d want 1/0", cmd_ready, duty);
        end
        mdl_duty = 0;
    endtask

    task automatic test_pause_equal();
        run_ramp(60, 20, 1, 3, 5, "pause");
        run_ramp(60, 7, 0, -1, 0, "equal");
    endtask

    task automatic test_back_to_back();
        run_ramp(90, 45, 0, -1, 0, "b2b_a");
        run_ramp(30, 25, 1, -1, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_extremes();
        test_abort_idle();
        test_abort();
        test_reset_mid();
        test_pause_equal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
